mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/stall_timer.sv | 24 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter state and the debug view.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

  typedef struct packed {
    arb_state_t  state;
    logic [2:0]  starve_cnt;
    logic [7:0]  stall_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/stall_timer.sv
// Counts stalled access cycles; expired flags the stall cycle that would reach TIMEOUT.
module stall_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       expired
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Combinational so the FSM leaves on the very edge the count reaches TIMEOUT.
  assign expired = enable && (({1'b0, count} + 9'd1) >= 9'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction/data) for a single RAM port with anti-starvation and timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err,
  output logic        gnt_d,
  output arb_dbg_t    dbg
);

  // Handshake: a requester holds its REN/WEN (and address/data) until its wait
  // output drops for one cycle; that cycle carries the load data. Dropping the
  // request earlier abandons the access without a completion pulse.

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_t state_q, state_d, st;
  logic [2:0] starve_cnt;
  logic [7:0] stall_cnt;
  logic       d_req, in_acc, gnt_req, i_done, d_done, expired;

  assign d_req   = dREN | dWEN;
  assign in_acc  = (state_q == IACC) || (state_q == DACC);
  assign gnt_req = (state_q == IACC) ? iREN : d_req;
  assign i_done  = !RST && (state_q == IACC) && iREN  && (ramstate == ACCESS);
  assign d_done  = !RST && (state_q == DACC) && d_req && (ramstate == ACCESS);
  // Reset forces the reset-value outputs even before the state register clears.
  assign st      = RST ? IDLE : state_q;

  stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (!in_acc),
    .enable  (in_acc && (ramstate != ACCESS)),
    .count   (stall_cnt),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = (iREN && (starve_cnt == STARVE_LIM)) ? IACC : DACC;
        end else if (iREN) begin
          state_d = IACC;
        end
      end
      IACC, DACC: begin
        if (ramstate == ERROR)       state_d = ERR;
        else if (!gnt_req)           state_d = IDLE;
        else if (ramstate == ACCESS) state_d = IDLE;
        else if (expired)            state_d = ERR;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= 3'd0;
    end else if ((state_q == IDLE) && (state_d == IACC)) begin
      starve_cnt <= 3'd0;
    end else if ((state_q == IDLE) && (state_d == DACC) && iREN &&
                 (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    gnt_d    = 1'b0;
    err      = 1'b0;
    iwait    = !i_done;
    dwait    = !d_done;
    iload    = i_done ? ramload : 32'd0;
    dload    = d_done ? ramload : 32'd0;
    case (st)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        gnt_d    = 1'b1;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  assign dbg = '{state: state_q, starve_cnt: starve_cnt, stall_cnt: stall_cnt};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: scenarios with hand-computed expectations.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err, gnt_d;
  ramstate_t   ramstate;
  arb_dbg_t    dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err), .gnt_d(gnt_d), .dbg(dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks: inputs change 1 time unit after the rising edge, checks at the falling edge.
  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE;
  endtask

  task automatic reset_dut();
    RST = 1;
    clear_inputs();
    cycle();
    cycle();
    RST = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_g;
  int         acc_cycles;

  initial begin
    RST = 1;
    clear_inputs();
    cycle();
    settle();
    check("rst_ramREN", ramREN, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_waits", {iwait, dwait}, 2'b11);
    check("rst_loads", iload | dload, 0);
    check("rst_gnt_err", {gnt_d, err}, 2'b00);
    cycle();
    RST = 0;

    // Scenario 1: instruction read with two BUSY cycles
    iREN = 1; iaddr = 32'h40;
    settle();
    check("s1_idle", dbg.state, IDLE);
    check("s1_idle_iwait", iwait, 1);
    cycle(); ramstate = BUSY;
    settle();
    check("s1_iacc_ren", {ramREN, ramWEN}, 2'b10);
    check("s1_iacc_addr", ramaddr, 32'h40);
    check("s1_busy_iwait", iwait, 1);
    check("s1_gnt_d", gnt_d, 0);
    cycle();
    settle();
    check("s1_busy2_iwait", iwait, 1);
    cycle(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check("s1_done_iwait", iwait, 0);
    check("s1_done_iload", iload, 32'hDEADBEEF);
    check("s1_done_dwait", dwait, 1);
    cycle(); iREN = 0; ramstate = FREE;
    settle();
    check("s1_after_state", dbg.state, IDLE);
    check("s1_after_iwait", iwait, 1);
    check("s1_after_iload", iload, 0);

    // Scenario 2: data write beats a simultaneous instruction read
    dWEN = 1; daddr = 32'h80; dstore = 32'h1234; iREN = 1; iaddr = 32'h44;
    cycle(); ramstate = ACCESS; ramload = 32'h55;
    settle();
    check("s2_dacc", dbg.state, DACC);
    check("s2_wen", {ramWEN, ramREN}, 2'b10);
    check("s2_addr", ramaddr, 32'h80);
    check("s2_store", ramstore, 32'h1234);
    check("s2_gnt_d", gnt_d, 1);
    check("s2_dwait", dwait, 0);
    check("s2_iwait", iwait, 1);
    check("s2_starve", dbg.starve_cnt, 1);
    cycle(); dWEN = 0; ramstate = FREE;
    settle();
    check("s2_turnaround", dbg.state, IDLE);
    cycle(); ramstate = ACCESS;
    settle();
    check("s2_iacc", dbg.state, IACC);
    check("s2_iacc_addr", ramaddr, 32'h44);
    check("s2_iacc_starve", dbg.starve_cnt, 0);
    check("s2_iacc_iwait", iwait, 0);
    cycle(); iREN = 0; ramstate = FREE;

    // Scenario 3: continuous contention, grant pattern D,D,D,D,I repeating
    reset_dut();
    exp_q = '{DACC, DACC, DACC, DACC, IACC, DACC, DACC, DACC, DACC, IACC};
    dREN = 1; iREN = 1; ramstate = ACCESS;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (dbg.state != IDLE) begin
        if (exp_q.size() == 0) begin
          check("s3_extra_grant", dbg.state, IDLE);
        end else begin
          exp_g = exp_q.pop_front();
          check("s3_grant", dbg.state, exp_g);
          if (exp_g == IACC) begin
            check("s3_starve_clr", dbg.starve_cnt, 0);
            check("s3_iwait", iwait, 0);
          end else begin
            check("s3_dwait", dwait, 0);
          end
        end
      end
      cycle();
    end
    check("s3_all_grants", exp_q.size(), 0);

    // Scenario 4: RAM stays BUSY until timeout
    reset_dut();
    dREN = 1; ramstate = BUSY;
    acc_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      settle();
      if (err) break;
      if (dbg.state == DACC) acc_cycles++;
      cycle();
    end
    check("s4_err", err, 1);
    check("s4_acc_cycles", acc_cycles, 255);
    cycle(); ramstate = ACCESS;
    cycle();
    settle();
    check("s4_err_held", dbg.state, ERR);
    check("s4_err_outs", {err, ramREN, ramWEN, dwait, iwait}, 5'b10011);
    check("s4_err_dload", dload, 0);
    cycle(); RST = 1;
    settle();
    check("s4_rst_err", err, 0);
    cycle(); RST = 0; dREN = 0; ramstate = FREE;
    settle();
    check("s4_post_state", dbg.state, IDLE);
    check("s4_post_err", err, 0);

    // Scenario 5: reset during DACC with completion pending
    reset_dut();
    dREN = 1; daddr = 32'h90; ramstate = BUSY;
    cycle(); ramstate = ACCESS; ramload = 32'hA5A5A5A5; RST = 1;
    settle();
    check("s5_no_pulse", dwait, 1);
    check("s5_dload", dload, 0);
    check("s5_outs", {ramREN, ramWEN, gnt_d, err}, 4'b0000);
    cycle(); RST = 0; dREN = 0; ramstate = FREE;
    settle();
    check("s5_state", dbg.state, IDLE);
    check("s5_addr", ramaddr, 0);
    check("s5_waits", {iwait, dwait}, 2'b11);

    // Scenario 6: data request abandoned before ACCESS
    reset_dut();
    dREN = 1; iREN = 1; ramstate = BUSY;
    cycle();
    settle();
    check("s6_dacc", dbg.state, DACC);
    check("s6_starve", dbg.starve_cnt, 1);
    cycle(); dREN = 0;
    settle();
    check("s6_no_pulse", dwait, 1);
    cycle();
    settle();
    check("s6_idle", dbg.state, IDLE);
    check("s6_starve_held", dbg.starve_cnt, 1);
    cycle(); iREN = 0;

    // Scenario 7: ERROR ignored in IDLE, fatal in an access state
    reset_dut();
    ramstate = ERROR;
    cycle();
    settle();
    check("s7_idle_ignores", dbg.state, IDLE);
    iREN = 1;
    cycle();
    settle();
    check("s7_iacc", dbg.state, IACC);
    cycle(); iREN = 0; ramstate = FREE;
    settle();
    check("s7_err", {err, dbg.state}, {1'b1, ERR});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
